// File: rtl/vec_cond_pkg.sv
// Shared types and constants for the vector conditional-execution unit:
// condition codes, branch opcodes, reduction modes and flush FSM states.
package vec_cond_pkg;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_LT = 4'd3,
    COND_GE = 4'd4,
    COND_GT = 4'd5,
    COND_LE = 4'd6,
    COND_NV = 4'd7
  } cond_e;

  localparam logic [3:0] OP_BR   = 4'b1000;
  localparam logic [3:0] OP_BCND = 4'b1001;

  localparam int BR_LANE0 = 0;
  localparam int BR_ALL   = 1;
  localparam int BR_ANY   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/vec_cond_logic_if.sv
// Execute-stage bundle between the pipeline and the conditional-execution unit.
// master drives decoder/ALU results, slave returns predicated enables and branch.
interface vec_cond_logic_if #(
  parameter int LANES = 4
);
  logic             stall_i;
  logic [LANES-1:0] lane_en_i;
  logic             flag_update_i;
  logic [LANES-1:0] alu_zero_i;
  logic [LANES-1:0] alu_neg_i;
  logic [3:0]       opcode_i;
  logic [3:0]       cond_i;
  logic             pcs_i;
  logic             reg_w_i;
  logic             mem_w_i;
  logic             pc_src_o;
  logic             post_alu_mux_sel_o;
  logic [LANES-1:0] reg_write_o;
  logic [LANES-1:0] mem_write_o;
  logic             flush_o;
  logic [LANES-1:0] zero_flags_o;
  logic [LANES-1:0] neg_flags_o;

  modport master (
    output stall_i, lane_en_i, flag_update_i, alu_zero_i, alu_neg_i,
           opcode_i, cond_i, pcs_i, reg_w_i, mem_w_i,
    input  pc_src_o, post_alu_mux_sel_o, reg_write_o, mem_write_o,
           flush_o, zero_flags_o, neg_flags_o
  );

  modport slave (
    input  stall_i, lane_en_i, flag_update_i, alu_zero_i, alu_neg_i,
           opcode_i, cond_i, pcs_i, reg_w_i, mem_w_i,
    output pc_src_o, post_alu_mux_sel_o, reg_write_o, mem_write_o,
           flush_o, zero_flags_o, neg_flags_o
  );
endinterface

// File: rtl/vec_cond_logic_eval.sv
// Single-lane condition evaluator: maps a 4-bit condition code and the lane's
// registered Z/N flags to a true/false result.
module vec_cond_eval
  import vec_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       z,
  input  logic       n,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_LT: cond_true = n;
      COND_GE: cond_true = ~n;
      COND_GT: cond_true = ~z & ~n;
      COND_LE: cond_true = z | n;
      default: cond_true = 1'b0;  // 7..15 never execute
    endcase
  end

endmodule

// File: rtl/vec_cond_logic.sv
// Per-lane predication and branch resolution: registered flags, lane reduction
// for conditional branches, and a flush FSM that blanks the wrong path.
module vec_cond_logic
  import vec_cond_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int BR_REDUCE    = 0
) (
  input  logic              clk,
  input  logic              reset,
  vec_cond_logic_if.slave   bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [LANES-1:0] zero_reg, zero_next;
  logic [LANES-1:0] neg_reg, neg_next;
  logic [LANES-1:0] cond_true;
  logic [LANES-1:0] pred;
  logic             br_red;
  logic             br_cond;
  logic             flush;
  logic             pc_src;
  logic             flag_we;
  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    vec_cond_eval u_eval (
      .cond      (bus.cond_i),
      .z         (zero_reg[gi]),
      .n         (neg_reg[gi]),
      .cond_true (cond_true[gi])
    );
  end

  assign pred = cond_true & bus.lane_en_i;

  // An all-lanes branch with no active lanes is deliberately not taken.
  always_comb begin
    br_red = 1'b0;
    case (BR_REDUCE)
      BR_ALL:  br_red = (bus.lane_en_i != '0) && (pred == bus.lane_en_i);
      BR_ANY:  br_red = |pred;
      default: br_red = pred[0];
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    if (bus.opcode_i == OP_BR)
      br_cond = 1'b1;
    else if (bus.opcode_i == OP_BCND)
      br_cond = br_red;
  end

  assign flush  = (state_reg == FLUSH);
  assign pc_src = bus.pcs_i & br_cond & ~flush;

  assign bus.pc_src_o           = pc_src;
  assign bus.post_alu_mux_sel_o = pc_src & (bus.opcode_i == OP_BCND);
  assign bus.reg_write_o        = {LANES{bus.reg_w_i & ~flush}} & pred;
  assign bus.mem_write_o        = {LANES{bus.mem_w_i & ~flush}} & pred;
  assign bus.flush_o            = flush;
  assign bus.zero_flags_o       = zero_reg;
  assign bus.neg_flags_o        = neg_reg;

  assign flag_we = bus.flag_update_i & ~bus.stall_i & ~flush;

  always_comb begin
    zero_next = zero_reg;
    neg_next  = neg_reg;
    if (flag_we) begin
      zero_next = (zero_reg & ~bus.lane_en_i) | (bus.alu_zero_i & bus.lane_en_i);
      neg_next  = (neg_reg  & ~bus.lane_en_i) | (bus.alu_neg_i  & bus.lane_en_i);
    end
  end

  // Counter holds remaining flush cycles minus one; stalls freeze it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pc_src && !bus.stall_i && (FLUSH_CYCLES > 0)) begin
          state_next = FLUSH;
          cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (!bus.stall_i) begin
          if (cnt_reg == '0)
            state_next = IDLE;
          else
            cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_reg  <= '0;
      neg_reg   <= '0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      zero_reg  <= zero_next;
      neg_reg   <= neg_next;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_vec_cond_logic.sv
// Bench for vec_cond_logic: four instances (lane0/all/any reduction with a
// 2-cycle flush, plus a no-flush build) share stimulus and one reference model.
module tb_vec_cond_logic;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, fu, pcs, rw, mw;
  logic [3:0] en, az, an, op, cond;

  logic       o_pc [NI];
  logic       o_sel[NI];
  logic       o_fl [NI];
  logic [3:0] o_rw [NI];
  logic [3:0] o_mw [NI];
  logic [3:0] o_z  [NI];
  logic [3:0] o_n  [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    vec_cond_logic_if #(.LANES(4)) bus ();
    assign bus.stall_i       = stall;
    assign bus.lane_en_i     = en;
    assign bus.flag_update_i = fu;
    assign bus.alu_zero_i    = az;
    assign bus.alu_neg_i     = an;
    assign bus.opcode_i      = op;
    assign bus.cond_i        = cond;
    assign bus.pcs_i         = pcs;
    assign bus.reg_w_i       = rw;
    assign bus.mem_w_i       = mw;
    assign o_pc[gi]  = bus.pc_src_o;
    assign o_sel[gi] = bus.post_alu_mux_sel_o;
    assign o_fl[gi]  = bus.flush_o;
    assign o_rw[gi]  = bus.reg_write_o;
    assign o_mw[gi]  = bus.mem_write_o;
    assign o_z[gi]   = bus.zero_flags_o;
    assign o_n[gi]   = bus.neg_flags_o;

    vec_cond_logic #(
      .LANES        (4),
      .FLUSH_CYCLES ((gi == 3) ? 0 : 2),
      .BR_REDUCE    ((gi == 3) ? 0 : gi)
    ) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
    );
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: flags and remaining wrong-path cycles per instance.
  logic [3:0] m_z [NI];
  logic [3:0] m_n [NI];
  int         m_left [NI];
  logic       e_pc [NI];
  logic       e_sel[NI];
  logic [3:0] e_rw [NI];
  logic [3:0] e_mw [NI];

  function automatic logic lane_cond(input logic [3:0] c, input logic z, input logic n);
    case (c)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return n;
      4'd4: return !n;
      4'd5: return !z && !n;
      4'd6: return z || n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_eval();
    for (int k = 0; k < NI; k++) begin
      logic [3:0] p;
      int  npred, nen, mode;
      logic red, br, fl;
      fl = (m_left[k] > 0);
      npred = 0; nen = 0;
      for (int l = 0; l < 4; l++) begin
        p[l] = en[l] && lane_cond(cond, m_z[k][l], m_n[k][l]);
        if (en[l]) nen++;
        if (p[l]) npred++;
      end
      mode = (k == 3) ? 0 : k;
      if (mode == 1)      red = (nen > 0) && (npred == nen);
      else if (mode == 2) red = (npred > 0);
      else                red = p[0];
      if (op == 4'd8)      br = 1'b1;
      else if (op == 4'd9) br = red;
      else                 br = 1'b0;
      e_pc[k]  = pcs && br && !fl;
      e_sel[k] = e_pc[k] && (op == 4'd9);
      e_rw[k]  = (rw && !fl) ? p : 4'd0;
      e_mw[k]  = (mw && !fl) ? p : 4'd0;
    end
  endtask

  task automatic model_commit();
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_z[k] = 4'd0; m_n[k] = 4'd0; m_left[k] = 0;
      end else begin
        if (fu && !stall && m_left[k] == 0)
          for (int l = 0; l < 4; l++)
            if (en[l]) begin
              m_z[k][l] = az[l];
              m_n[k][l] = an[l];
            end
        if (m_left[k] > 0) begin
          if (!stall) m_left[k]--;
        end else if (e_pc[k] && !stall) begin
          m_left[k] = (k == 3) ? 0 : 2;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %h expected %h", nm, k, act, exp);
  endtask

  task automatic check_model(input string tag);
    model_eval();
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_pc"},  k, {3'b0, o_pc[k]},  {3'b0, e_pc[k]});
      chk({tag, "_sel"}, k, {3'b0, o_sel[k]}, {3'b0, e_sel[k]});
      chk({tag, "_fl"},  k, {3'b0, o_fl[k]},  {3'b0, m_left[k] > 0});
      chk({tag, "_rw"},  k, o_rw[k], e_rw[k]);
      chk({tag, "_mw"},  k, o_mw[k], e_mw[k]);
      chk({tag, "_z"},   k, o_z[k],  m_z[k]);
      chk({tag, "_n"},   k, o_n[k],  m_n[k]);
    end
  endtask

  typedef struct {
    logic       rst, stall, fu, pcs, rw;
    logic [3:0] en, az, an, op, cond;
    logic [3:0] x_rw;
    logic       x_pc, x_sel, x_fl;
    logic [3:0] x_z, x_n;
  } vec_t;

  function automatic vec_t mk(input logic r, s, f, p, w, input logic [3:0] e, a, n, o, c,
                              input logic [3:0] xrw, input logic xpc, xsel, xfl,
                              input logic [3:0] xz, xn);
    vec_t v;
    v.rst = r; v.stall = s; v.fu = f; v.pcs = p; v.rw = w;
    v.en = e; v.az = a; v.an = n; v.op = o; v.cond = c;
    v.x_rw = xrw; v.x_pc = xpc; v.x_sel = xsel; v.x_fl = xfl; v.x_z = xz; v.x_n = xn;
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    // Expectations are for instance 0 (lane-0 reduction, 2-cycle flush).
    //              rst st fu pcs rw  en     az     an     op     cond   x_rw  pc sel fl  x_z    x_n
    tbl[0]  = mk(0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'd2, 4'hF, 0, 0, 0, 4'h0, 4'h0);
    tbl[1]  = mk(0, 0, 1, 0, 1, 4'hF, 4'h1, 4'h0, 4'h0, 4'd2, 4'hF, 0, 0, 0, 4'h0, 4'h0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'd2, 4'hE, 0, 0, 0, 4'h1, 4'h0);
    tbl[3]  = mk(0, 0, 0, 1, 0, 4'hF, 4'h0, 4'h0, 4'h9, 4'd1, 4'h0, 1, 1, 0, 4'h1, 4'h0);
    tbl[4]  = mk(0, 0, 1, 1, 1, 4'hF, 4'hF, 4'hF, 4'h8, 4'd0, 4'h0, 0, 0, 1, 4'h1, 4'h0);
    tbl[5]  = mk(0, 0, 1, 1, 1, 4'hF, 4'hF, 4'hF, 4'h8, 4'd0, 4'h0, 0, 0, 1, 4'h1, 4'h0);
    tbl[6]  = mk(0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0, 4'h8, 4'd0, 4'hF, 0, 0, 0, 4'h1, 4'h0);
    tbl[7]  = mk(0, 0, 0, 1, 0, 4'hF, 4'h0, 4'h0, 4'h8, 4'd0, 4'h0, 1, 0, 0, 4'h1, 4'h0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'd0, 4'h0, 0, 0, 1, 4'h1, 4'h0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'd0, 4'h0, 0, 0, 1, 4'h1, 4'h0);
    tbl[10] = mk(0, 1, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'd0, 4'h0, 0, 0, 1, 4'h1, 4'h0);
    tbl[11] = mk(0, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'd0, 4'h0, 0, 0, 1, 4'h1, 4'h0);
    tbl[12] = mk(0, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'd0, 4'h0, 0, 0, 1, 4'h1, 4'h0);
    tbl[13] = mk(0, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'd0, 4'h0, 0, 0, 0, 4'h1, 4'h0);
    tbl[14] = mk(0, 0, 1, 0, 0, 4'h3, 4'hF, 4'hF, 4'h0, 4'd0, 4'h0, 0, 0, 0, 4'h1, 4'h0);
    tbl[15] = mk(0, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'd0, 4'h0, 0, 0, 0, 4'h3, 4'h3);
    tbl[16] = mk(0, 0, 0, 1, 0, 4'hF, 4'h0, 4'h0, 4'h8, 4'd0, 4'h0, 1, 0, 0, 4'h3, 4'h3);
    tbl[17] = mk(1, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'd0, 4'h0, 0, 0, 1, 4'h3, 4'h3);
    tbl[18] = mk(0, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'd0, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    tbl[19] = mk(0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'd5, 4'hF, 0, 0, 0, 4'h0, 4'h0);
    tbl[20] = mk(0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'd4, 4'hF, 0, 0, 0, 4'h0, 4'h0);
    tbl[21] = mk(0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'd3, 4'h0, 0, 0, 0, 4'h0, 4'h0);

    rst = 1'b1; stall = 1'b0; fu = 1'b0; pcs = 1'b0; rw = 1'b0; mw = 1'b0;
    en = 4'h0; az = 4'h0; an = 4'h0; op = 4'h0; cond = 4'h0;
    for (int k = 0; k < NI; k++) begin
      m_z[k] = 4'd0; m_n[k] = 4'd0; m_left[k] = 0;
    end
    @(posedge clk);
    model_commit();

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; stall = tbl[i].stall; fu = tbl[i].fu; pcs = tbl[i].pcs;
      rw = tbl[i].rw; mw = tbl[i].rw; en = tbl[i].en; az = tbl[i].az; an = tbl[i].an;
      op = tbl[i].op; cond = tbl[i].cond;
      #1;
      chk("vec_rw",  i, o_rw[0], tbl[i].x_rw);
      chk("vec_mw",  i, o_mw[0], tbl[i].x_rw);
      chk("vec_pc",  i, {3'b0, o_pc[0]},  {3'b0, tbl[i].x_pc});
      chk("vec_sel", i, {3'b0, o_sel[0]}, {3'b0, tbl[i].x_sel});
      chk("vec_fl",  i, {3'b0, o_fl[0]},  {3'b0, tbl[i].x_fl});
      chk("vec_z",   i, o_z[0], tbl[i].x_z);
      chk("vec_n",   i, o_n[0], tbl[i].x_n);
      check_model("vecm");
      $display("vec %0d: op=%h cond=%0d en=%h pc=%0b fl=%0b rw=%h z=%h n=%h",
               i, op, cond, en, o_pc[0], o_fl[0], o_rw[0], o_z[0], o_n[0]);
      @(posedge clk);
      model_commit();
    end

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 4) == 0);
      fu    = $urandom_range(0, 1) == 1;
      pcs   = $urandom_range(0, 2) != 0;
      rw    = $urandom_range(0, 1) == 1;
      mw    = $urandom_range(0, 1) == 1;
      en    = 4'($urandom);
      az    = 4'($urandom);
      an    = 4'($urandom);
      op    = ($urandom_range(0, 1) == 1) ? (4'h8 | 4'($urandom_range(0, 1))) : 4'($urandom);
      cond  = 4'($urandom);
      #1;
      check_model("rnd");
      $display("rnd %0d: rst=%0b st=%0b op=%h cond=%0d en=%h pc=%0b%0b%0b%0b fl=%0b%0b%0b%0b",
               i, rst, stall, op, cond, en, o_pc[0], o_pc[1], o_pc[2], o_pc[3],
               o_fl[0], o_fl[1], o_fl[2], o_fl[3]);
      @(posedge clk);
      model_commit();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vec_cond_logic.md
# vec_cond_logic

Per-lane conditional-execution and branch-resolution unit for the vector datapath, located in the execute stage after the ALU lanes. It holds registered zero/negative flags per lane, evaluates a 4-bit condition code against them, and generates per-lane predicated register and memory write enables. It also resolves unconditional and conditional branches using a configurable lane reduction. After a taken branch, a flush state machine suppresses writes for a fixed number of cycles.

## Interface
- LANES, 4, number of vector lanes (≥1)
- FLUSH_CYCLES, 2, cycles of write/flag suppression after a taken branch (0 disables flush)
- BR_REDUCE, 0, branch reduction: 0 = lane 0 only, 1 = all enabled lanes, 2 = any enabled lane
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- stall_i  in  1  pipeline stall; freezes flags and flush counter
- lane_en_i  in  LANES  active-lane mask for the current instruction
- flag_update_i  in  1  instruction writes flags
- alu_zero_i  in  LANES  per-lane ALU zero result
- alu_neg_i  in  LANES  per-lane ALU negative result
- opcode_i  in  4  execute-stage opcode
- cond_i  in  4  condition code
- pcs_i  in  1  decoder branch request
- reg_w_i  in  1  decoder register write request
- mem_w_i  in  1  decoder memory write request
- pc_src_o  out  1  branch taken
- post_alu_mux_sel_o  out  1  select branch target path after ALU
- reg_write_o  out  LANES  predicated register write enables
- mem_write_o  out  LANES  predicated memory write enables
- flush_o  out  1  wrong-path suppression active
- zero_flags_o  out  LANES  registered zero flags
- neg_flags_o  out  LANES  registered negative flags

## Operation
- Condition evaluation per lane on *registered* flags Z, N:
  - 0 AL = 1
  - 1 EQ = Z
  - 2 NE = ~Z
  - 3 LT = N
  - 4 GE = ~N
  - 5 GT = ~Z & ~N
  - 6 LE = Z | N
  - 7–15 NV = 0
- pred[l] = cond_true[l] & lane_en_i[l].
- reg_write_o[l] = reg_w_i & pred[l] & ~flush_o. mem_write_o[l] = mem_w_i & pred[l] & ~flush_o.
- Branch opcodes: OP_BR = 4'b1000 and OP_BCND = 4'b1001.
  - br_cond = 1 for OP_BR.
  - For OP_BCND, br_cond is the reduction of pred per BR_REDUCE. For BR_REDUCE=1, the reduction is AND over enabled lanes and is 0 if lane_en_i = 0. For BR_REDUCE=2, it is OR over enabled lanes.
  - For any other opcode, br_cond = 0.
- pc_src_o = pcs_i & br_cond & ~flush_o.
- post_alu_mux_sel_o = pc_src_o & (opcode_i == OP_BCND).
- Flag update: when flag_update_i & ~stall_i & ~flush_o, each lane l with lane_en_i[l] = 1 loads alu_zero_i[l] and alu_neg_i[l]. Disabled lanes hold their flags.
- FSM states: IDLE, FLUSH.
  - IDLE → FLUSH when pc_src_o & ~stall_i & FLUSH_CYCLES > 0. Counter loads FLUSH_CYCLES-1.
  - FLUSH: flush_o = 1. The counter decrements each non-stalled cycle. When it reaches 0 on a non-stalled cycle, the FSM returns to IDLE. During stall the counter holds.
  - When FLUSH_CYCLES = 0, the FSM stays in IDLE permanently.

## Timing
- All outputs other than flags and flush_o are combinational from the inputs and registered state, in the same cycle.
- Flags written in cycle t are visible to the condition evaluation in cycle t+1. No bypass.
- Taken branch in cycle t: flush_o is high in cycles t+1 .. t+FLUSH_CYCLES, counting non-stalled cycles only.
- A flag update and a taken branch in the same cycle: the branch uses the old flags, and the update is still committed.
- A branch request while flush_o = 1 is ignored: pc_src_o = 0 and there is no re-entry.
- Reset: flags = 0, state = IDLE, counter = 0, flush_o = 0.
  - With flags = 0 after reset, NE, GE and GT evaluate true.
  - Reset asserted mid-flush aborts the flush in the next cycle.

## Structure
- Package vec_cond_pkg contains:
  - cond_e enum (AL..LE, NV)
  - OP_BR and OP_BCND constants
  - BR_REDUCE encodings
  - state_e {IDLE, FLUSH}
- Sub-module vec_cond_eval: combinational, one instance per lane via generate. Inputs are cond, Z and N. Output is cond_true.
- Top module contains the flag registers, reduction logic, FSM and counter.

## Test plan
- Reset, then cond=NE, reg_w_i=1, lane_en_i=4'hF → reg_write_o=4'hF. flag_update with alu_zero_i=4'b0101 → reg_write_o=4'b1010 in the next cycle.
- opcode=OP_BCND, cond=EQ, flags Z=4'b0001, pcs_i=1, BR_REDUCE=0 → pc_src_o=1 and post_alu_mux_sel_o=1. With BR_REDUCE=1 → pc_src_o=0.
- OP_BR taken with FLUSH_CYCLES=2 → flush_o high for exactly 2 cycles, with writes 0 and flags frozen. A second OP_BR during the flush → pc_src_o=0.
- Taken branch followed by stall_i=1 for 3 cycles during FLUSH → flush_o lasts 2 non-stalled cycles (5 cycles total).
- flag_update_i with lane_en_i=4'b0011 → only lanes 0–1 change. zero_flags_o and neg_flags_o are checked.
- Reset asserted in the first FLUSH cycle → flush_o=0 in the next cycle and flags=0.
